// File: rtl/draw_request_arbiter_pkg.sv
// Shared types and limits for the draw request arbiter.
package draw_arb_pkg;

  localparam int unsigned DRAW_COORD_W = 32;
  localparam int unsigned DRAW_COLOR_W = 32;
  localparam int unsigned DRAW_MAX_REQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ADDR,
    ST_DATA,
    ST_FLIP
  } draw_arb_state_t;

endpackage

// File: rtl/draw_request_arbiter_if.sv
// Requester, flip and memory-manager signals of the draw request arbiter.
interface draw_request_arbiter_if
  import draw_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COORD_W = DRAW_COORD_W,
  parameter int unsigned COLOR_W = DRAW_COLOR_W
);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*COORD_W-1:0] req_x;
  logic [NUM_REQ*COORD_W-1:0] req_y;
  logic [NUM_REQ*COLOR_W-1:0] req_color;
  logic [NUM_REQ-1:0]         ack;
  logic                       flip_req;
  logic                       flip_ack;
  logic                       hready;
  logic                       enable;
  logic [COORD_W-1:0]         x;
  logic [COORD_W-1:0]         y;
  logic [COLOR_W-1:0]         color;
  logic                       flip_buffer;
  logic                       busy;

  // Arbiter side.
  modport master (
    input  req, req_x, req_y, req_color, flip_req, hready,
    output ack, flip_ack, enable, x, y, color, flip_buffer, busy
  );

  // Requester / memory-manager side.
  modport slave (
    output req, req_x, req_y, req_color, flip_req, hready,
    input  ack, flip_ack, enable, x, y, color, flip_buffer, busy
  );

endinterface

// File: rtl/draw_request_arbiter_picker.sv
// Combinational picker: first pending request after the pointer, wrapping around.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_request_arbiter.sv
// Shares the framebuffer pixel-write path among drawing engines and serialises flips.
// Define DRAW_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module draw_request_arbiter
  import draw_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COORD_W = DRAW_COORD_W,
  parameter int unsigned COLOR_W = DRAW_COLOR_W
) (
  input logic                   clk,
  input logic                   n_rst,
  draw_request_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > DRAW_MAX_REQ) begin : g_bad_num_req
    $error("draw_request_arbiter: NUM_REQ out of range");
  end

  draw_arb_state_t    state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_ptr;

`ifdef DRAW_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d, gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) gnt_idx = IDX_W'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_ISSUE) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ptr_q <= IDX_W'(NUM_REQ - 1);
    else        ptr_q <= ptr_d;
  end

  assign pick_ptr = ptr_q;
`else
  // Pointer parked at the top index makes the search start at requester 0.
  assign pick_ptr = IDX_W'(NUM_REQ - 1);
`endif

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .grant (pick_gnt),
    .valid (pick_vld)
  );

  // Next state; grant and pixel payload are latched only when leaving IDLE for ISSUE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flip_req) begin
          state_d = ST_FLIP;
        end else if (pick_vld) begin
          state_d = ST_ISSUE;
          gnt_d   = pick_gnt;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
              x_d     = bus.req_x[i*COORD_W +: COORD_W];
              y_d     = bus.req_y[i*COORD_W +: COORD_W];
              color_d = bus.req_color[i*COLOR_W +: COLOR_W];
            end
          end
        end
      end
      ST_ISSUE: state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_DATA;
      ST_DATA:  if (bus.hready) state_d = ST_IDLE;
      ST_FLIP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  // Strobes decode straight from the state register.
  assign bus.enable      = (state_q == ST_ISSUE);
  assign bus.ack         = (state_q == ST_ISSUE) ? gnt_q : '0;
  assign bus.flip_buffer = (state_q == ST_FLIP);
  assign bus.flip_ack    = (state_q == ST_FLIP);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.color       = color_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Directed self-checking bench for draw_request_arbiter.
module tb_draw_request_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned COORD_W = 32;
  localparam int unsigned COLOR_W = 32;

  logic        clk = 1'b0;
  logic        n_rst;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  draw_request_arbiter_if #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) bus ();

  draw_request_arbiter #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_req(input int unsigned i, input logic [31:0] xv,
                          input logic [31:0] yv, input logic [31:0] cv);
    bus.req_x[i*COORD_W +: COORD_W]     = xv;
    bus.req_y[i*COORD_W +: COORD_W]     = yv;
    bus.req_color[i*COLOR_W +: COLOR_W] = cv;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, 64'(bus.enable), 64'd0);
    check({tag, "_ack"},    64'(bus.ack),    64'd0);
    check({tag, "_flip"},   64'({bus.flip_buffer, bus.flip_ack}), 64'd0);
    check({tag, "_busy"},   64'(bus.busy),   64'd0);
    check({tag, "_xyc"},    64'(bus.x | bus.y | bus.color), 64'd0);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  logic [NUM_REQ-1:0] exp_gnt;
  int unsigned        cyc;

  initial begin
    n_rst        = 1'b0;
    bus.req      = '0;
    bus.req_x    = '0;
    bus.req_y    = '0;
    bus.req_color = '0;
    bus.flip_req = 1'b0;
    bus.hready   = 1'b1;
    do_reset();
    check_reset_outputs("rst");

    // Single pixel from requester 0.
    load_req(0, 32'h55, 32'h11, 32'hFF);
    bus.req = 4'b0001;
    tick();
    check("p1_enable", 64'(bus.enable), 64'd1);
    check("p1_ack",    64'(bus.ack),    64'h1);
    check("p1_x",      64'(bus.x),      64'h55);
    check("p1_y",      64'(bus.y),      64'h11);
    check("p1_color",  64'(bus.color),  64'hFF);
    bus.req = '0;
    tick();
    check("p1_addr_enable", 64'(bus.enable), 64'd0);
    check("p1_addr_busy",   64'(bus.busy),   64'd1);
    tick();
    check("p1_data_busy",   64'(bus.busy),   64'd1);
    tick();
    check("p1_idle_busy",   64'(bus.busy),   64'd0);
    check("p1_hold_x",      64'(bus.x),      64'h55);

    // All four requesters held; grants every 4 cycles.
    do_reset();
    for (int unsigned i = 0; i < NUM_REQ; i++)
      load_req(i, 32'h10 + i, 32'h20 + i, 32'h30 + i);
    bus.req = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      if (k > 0) begin
        for (int unsigned j = 0; j < 3; j++) begin
          tick();
          check("rr_gap_enable", 64'(bus.enable), 64'd0);
        end
      end
      tick();
`ifdef DRAW_ARB_RR_EN
      exp_gnt = NUM_REQ'(1 << (k % NUM_REQ));
`else
      exp_gnt = 4'b0001;
`endif
      check("rr_enable", 64'(bus.enable), 64'd1);
      check("rr_ack",    64'(bus.ack),    64'(exp_gnt));
`ifdef DRAW_ARB_RR_EN
      check("rr_x",      64'(bus.x),      64'(32'h10 + (k % NUM_REQ)));
`else
      check("rr_x",      64'(bus.x),      64'h10);
`endif
    end
    bus.req = '0;
    tick();
    tick();
    tick();
    check("rr_idle_busy", 64'(bus.busy), 64'd0);

    // Two cycles of hready low in DATA.
    bus.req = 4'b0010;
    tick();
    check("st_ack", 64'(bus.ack), 64'h2);
    bus.req = '0;
    tick();
    bus.hready = 1'b0;
    tick();
    check("st_data_busy", 64'(bus.busy), 64'd1);
    tick();
    check("st_wait1_busy", 64'(bus.busy), 64'd1);
    tick();
    check("st_wait2_busy", 64'(bus.busy), 64'd1);
    check("st_wait2_enable", 64'(bus.enable), 64'd0);
    bus.hready = 1'b1;
    cyc = 5;
    while (bus.busy && cyc < 20) begin
      tick();
      cyc++;
    end
    check("st_pixel_cycles", 64'(cyc), 64'd6);

    // Flip raised during ADDR while requester 1 waits.
    bus.req = 4'b0001;
    tick();
    check("fa_ack0", 64'(bus.ack), 64'h1);
    bus.req = 4'b0010;
    tick();
    bus.flip_req = 1'b1;
    tick();
    check("fa_data_flip", 64'(bus.flip_ack), 64'd0);
    tick();
    check("fa_idle_busy", 64'(bus.busy), 64'd0);
    tick();
    check("fa_flip_buffer", 64'(bus.flip_buffer), 64'd1);
    check("fa_flip_ack",    64'(bus.flip_ack),    64'd1);
    check("fa_flip_enable", 64'(bus.enable),      64'd0);
    bus.flip_req = 1'b0;
    tick();
    check("fa_after_flip_busy", 64'(bus.busy), 64'd0);
    tick();
    check("fa_ack1", 64'(bus.ack), 64'h2);
    bus.req = '0;
    tick();
    tick();
    tick();

    // Flip and pixel together in IDLE: flip first.
    bus.flip_req = 1'b1;
    bus.req      = 4'b0001;
    tick();
    check("fb_flip_ack", 64'(bus.flip_ack), 64'd1);
    check("fb_ack_none", 64'(bus.ack),      64'd0);
    bus.flip_req = 1'b0;
    tick();
    check("fb_idle_busy", 64'(bus.busy), 64'd0);
    tick();
    check("fb_enable", 64'(bus.enable), 64'd1);
    check("fb_ack",    64'(bus.ack),    64'h1);
    bus.req = '0;

    // Asynchronous reset while stalled in DATA.
    tick();
    bus.hready = 1'b0;
    tick();
    check("ar_data_busy", 64'(bus.busy), 64'd1);
    n_rst = 1'b0;
    #1;
    check_reset_outputs("ar");
    bus.hready = 1'b1;
    tick();
    tick();
    n_rst   = 1'b1;
    bus.req = 4'b1111;
    tick();
    check("ar_first_ack", 64'(bus.ack), 64'h1);
    check("ar_first_x",   64'(bus.x),   64'h10);
    bus.req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
